// File: rtl/sysctrl_irq_wb.sv
// Wishbone system-control block: clock/trap routing enables plus an
// edge-triggered, maskable interrupt aggregator with sticky W1C status.
module sysctrl_irq_wb #(
   parameter logic [31:0] BASE_ADR = 32'h2F00_0000,
   parameter int unsigned NUM_CLK  = 2,
   parameter int unsigned NUM_IRQ  = 2
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               wb_stb_i,
   input  logic               wb_cyc_i,
   input  logic               wb_we_i,
   input  logic [3:0]         wb_sel_i,
   input  logic [31:0]        wb_adr_i,
   input  logic [31:0]        wb_dat_i,
   output logic               wb_ack_o,
   output logic [31:0]        wb_dat_o,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic [NUM_CLK-1:0] clk_out_dest,
   output logic               trap_out_dest,
   output logic               irq_o
);

   localparam logic [7:0]  OFF_CLK_OUT  = 8'h00;
   localparam logic [7:0]  OFF_TRAP_OUT = 8'h04;
   localparam logic [7:0]  OFF_IRQ_SRC  = 8'h08;
   localparam logic [7:0]  OFF_IRQ_STAT = 8'h0C;
   localparam logic [7:0]  OFF_IRQ_MASK = 8'h10;
   localparam logic [7:0]  OFF_ID       = 8'h14;
   localparam logic [31:0] ID_VALUE     = {8'h5C, 8'd0, 8'(NUM_CLK), 8'(NUM_IRQ)};

   logic [NUM_CLK-1:0] clk_out_q,  clk_out_d;
   logic               trap_out_q, trap_out_d;
   logic [NUM_IRQ-1:0] irq_src_q,  irq_src_d;
   logic [NUM_IRQ-1:0] irq_stat_q, irq_stat_d;
   logic [NUM_IRQ-1:0] irq_mask_q, irq_mask_d;
   logic [NUM_IRQ-1:0] sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
   logic               ack_q, ack_d;
   logic [31:0]        dat_q, dat_d;
   logic               irq_q, irq_d;

   logic               acc_c, wr_c, rd_c;
   logic [7:0]         off_c;
   logic [31:0]        bmask_c, rdata_c;
   logic [NUM_IRQ-1:0] set_c;

   // Bus decode, register update and read mux
   always_comb begin
      clk_out_d  = clk_out_q;
      trap_out_d = trap_out_q;
      irq_src_d  = irq_src_q;
      irq_mask_d = irq_mask_q;
      irq_stat_d = irq_stat_q;
      dat_d      = dat_q;
      rdata_c    = 32'd0;
      bmask_c    = 32'd0;

      sync1_d = irq_in;
      sync2_d = sync1_q;
      sync3_d = sync2_q;

      acc_c = wb_stb_i & wb_cyc_i & (wb_adr_i[31:8] == BASE_ADR[31:8]) & ~ack_q;
      wr_c  = acc_c & wb_we_i;
      rd_c  = acc_c & ~wb_we_i;
      off_c = wb_adr_i[7:0];
      ack_d = acc_c;

      for (int n = 0; n < 4; n++) begin
         bmask_c[8*n +: 8] = {8{wb_sel_i[n]}};
      end

      unique case (off_c)
         OFF_CLK_OUT:  rdata_c = 32'(clk_out_q);
         OFF_TRAP_OUT: rdata_c = 32'(trap_out_q);
         OFF_IRQ_SRC:  rdata_c = 32'(irq_src_q);
         OFF_IRQ_STAT: rdata_c = 32'(irq_stat_q);
         OFF_IRQ_MASK: rdata_c = 32'(irq_mask_q);
         OFF_ID:       rdata_c = ID_VALUE;
         default:      rdata_c = 32'd0;
      endcase

      if (rd_c) begin
         dat_d = rdata_c;
      end

      // Byte-lane merge: unselected lanes keep the current register contents
      if (wr_c) begin
         unique case (off_c)
            OFF_CLK_OUT:  clk_out_d  = NUM_CLK'((32'(clk_out_q) & ~bmask_c) | (wb_dat_i & bmask_c));
            OFF_TRAP_OUT: trap_out_d = wb_sel_i[0] ? wb_dat_i[0] : trap_out_q;
            OFF_IRQ_SRC:  irq_src_d  = NUM_IRQ'((32'(irq_src_q) & ~bmask_c) | (wb_dat_i & bmask_c));
            OFF_IRQ_STAT: irq_stat_d = irq_stat_q & ~NUM_IRQ'(wb_dat_i & bmask_c);
            OFF_IRQ_MASK: irq_mask_d = NUM_IRQ'((32'(irq_mask_q) & ~bmask_c) | (wb_dat_i & bmask_c));
            default:      ;
         endcase
      end

      // A detected edge wins over a same-cycle clear
      set_c      = sync2_q & ~sync3_q & irq_src_q;
      irq_stat_d = irq_stat_d | set_c;

      irq_d = |(irq_stat_q & irq_mask_q);
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         clk_out_q  <= '0;
         trap_out_q <= 1'b0;
         irq_src_q  <= '0;
         irq_stat_q <= '0;
         irq_mask_q <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         sync3_q    <= '0;
         ack_q      <= 1'b0;
         dat_q      <= 32'd0;
         irq_q      <= 1'b0;
      end else begin
         clk_out_q  <= clk_out_d;
         trap_out_q <= trap_out_d;
         irq_src_q  <= irq_src_d;
         irq_stat_q <= irq_stat_d;
         irq_mask_q <= irq_mask_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         sync3_q    <= sync3_d;
         ack_q      <= ack_d;
         dat_q      <= dat_d;
         irq_q      <= irq_d;
      end
   end

   assign wb_ack_o      = ack_q;
   assign wb_dat_o      = dat_q;
   assign clk_out_dest  = clk_out_q;
   assign trap_out_dest = trap_out_q;
   assign irq_o         = irq_q;

endmodule

// File: tb/tb_sysctrl_irq_wb.sv
// Directed bench for sysctrl_irq_wb with default parameters.
module tb_sysctrl_irq_wb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = 32'd0, wdat = 32'd0;
   logic        ack;
   logic [31:0] rdat;
   logic [1:0]  irq_in = 2'b00;
   logic [1:0]  clk_out_dest;
   logic        trap_out_dest;
   logic        irq_o;

   int tests = 0;
   int fails = 0;
   logic [31:0] rd;
   int acks;

   localparam logic [31:0] BASE = 32'h2F00_0000;

   sysctrl_irq_wb dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_stb_i(stb), .wb_cyc_i(cyc),
      .wb_we_i(we), .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat),
      .wb_ack_o(ack), .wb_dat_o(rdat), .irq_in(irq_in),
      .clk_out_dest(clk_out_dest), .trap_out_dest(trap_out_dest), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk); #1;
   endtask

   task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] q);
      int n = 0;
      stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
      do begin
         cycle();
         n++;
      end while (!ack && n < 10);
      check("ack_seen", 32'(ack), 32'd1);
      q = rdat;
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      cycle();
   endtask

   task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] dummy;
      wb_access(1'b1, BASE | 32'(off), d, s, dummy);
   endtask

   task automatic wb_read(input logic [7:0] off, output logic [31:0] q);
      wb_access(1'b0, BASE | 32'(off), 32'd0, 4'hF, q);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_dat", rdat, 32'd0);
      check("rst_irq", 32'(irq_o), 32'd0);
      check("rst_clkout", 32'(clk_out_dest), 32'd0);
      check("rst_trap", 32'(trap_out_dest), 32'd0);
      rst = 1'b0;
      cycle();

      // Basic RW and ID
      wb_write(8'h00, 32'h1, 4'hF);
      wb_write(8'h04, 32'h1, 4'hF);
      wb_write(8'h08, 32'h1, 4'hF);
      wb_read(8'h00, rd); check("clk_out_rd", rd, 32'h1);
      wb_read(8'h04, rd); check("trap_out_rd", rd, 32'h1);
      wb_read(8'h08, rd); check("irq_src_rd", rd, 32'h1);
      check("clk_out_dest", 32'(clk_out_dest), 32'h1);
      check("trap_out_dest", 32'(trap_out_dest), 32'h1);
      wb_read(8'h14, rd); check("id_rd", rd, 32'h5C00_0202);

      // Byte select, width truncation, RO ID, unmapped read
      wb_write(8'h08, 32'hFFFF_FFFF, 4'b0001);
      wb_read(8'h08, rd); check("irq_src_sel", rd, 32'h3);
      wb_write(8'h00, 32'h0000_0200, 4'b1110);
      wb_read(8'h00, rd); check("clk_out_nosel", rd, 32'h1);
      wb_write(8'h14, 32'h1234_5678, 4'hF);
      wb_read(8'h14, rd); check("id_ro", rd, 32'h5C00_0202);
      wb_read(8'h20, rd); check("unmapped_rd", rd, 32'h0);

      // Interrupt set, mask, W1C
      wb_write(8'h08, 32'h1, 4'hF);
      wb_write(8'h10, 32'h1, 4'hF);
      irq_in[0] = 1'b1;
      begin
         int n = 0;
         do begin cycle(); n++; end while (!irq_o && n < 5);
      end
      check("irq_rise", 32'(irq_o), 32'd1);
      irq_in[0] = 1'b0;
      wb_read(8'h0C, rd); check("status_set", rd, 32'h1);
      stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE | 32'h0C; wdat = 32'h1; sel = 4'hF;
      cycle();
      check("w1c_ack", 32'(ack), 32'd1);
      check("irq_hold", 32'(irq_o), 32'd1);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      cycle();
      check("irq_fall", 32'(irq_o), 32'd0);
      wb_read(8'h0C, rd); check("status_clr", rd, 32'h0);

      // Disabled channel drops its edge
      wb_write(8'h08, 32'h0, 4'hF);
      irq_in[1] = 1'b1;
      repeat (5) cycle();
      irq_in[1] = 1'b0;
      repeat (4) cycle();
      wb_read(8'h0C, rd); check("status_disabled", rd, 32'h0);

      // W1C coincident with a new edge on channel 1: set wins
      wb_write(8'h08, 32'h2, 4'hF);
      repeat (3) cycle();
      wb_read(8'h0C, rd); check("status_no_replay", rd, 32'h0);
      irq_in[1] = 1'b1;
      cycle();
      cycle();
      stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE | 32'h0C; wdat = 32'h2; sel = 4'hF;
      cycle();
      check("coincide_ack", 32'(ack), 32'd1);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      cycle();
      irq_in[1] = 1'b0;
      wb_read(8'h0C, rd); check("set_wins", rd, 32'h2);

      // Foreign address: no ack, no change
      acks = 0;
      stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h3000_0000; wdat = 32'h0; sel = 4'hF;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (ack) acks++;
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      cycle();
      check("foreign_noack", 32'(acks), 32'd0);
      wb_read(8'h00, rd); check("foreign_nochg", rd, 32'h1);

      // Reset during a write in progress
      stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE | 32'h04; wdat = 32'h1; sel = 4'hF;
      #2 rst = 1'b1;
      #1 check("rst_mid_ack", 32'(ack), 32'd0);
      cycle();
      check("rst_hold_ack", 32'(ack), 32'd0);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      cycle();
      rst = 1'b0;
      cycle();
      wb_read(8'h04, rd); check("rst_trap_rd", rd, 32'h0);
      wb_read(8'h00, rd); check("rst_clk_rd", rd, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
